// File: rtl/snn_collector_pkg.sv
// Shared definitions for the SNN spike collector.
// Holds the frame FSM state type, the class-index width helper and the
// default sizing constants used by the collector top level.
package snn_collector_pkg;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_NUM_TICKS   = 16;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RFIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SCAN  = 2'd1,
    PUSH  = 2'd2
  } state_e;

  // Width of a class index; a single-class build still needs one bit.
  function automatic int clsWidth(input int numClasses);
    return (numClasses > 1) ? $clog2(numClasses) : 1;
  endfunction

endpackage

// File: rtl/snn_result_fifo.sv
// Synchronous first-word-fall-through FIFO for inference results.
// rdata_o always shows the head entry and reads as zero while empty.
// A pop and a push in the same cycle while full both succeed.
// DEPTH must be a power of two and at least 2.
module snn_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  // Pointer advance: each pointer moves by one on an accepted push or pop.
  always_comb begin
    wrPtr_d = wrPtr_q + {{AW{1'b0}}, doPush};
    rdPtr_d = rdPtr_q + {{AW{1'b0}}, doPop};
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage write; contents need no reset because the read side masks them while empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/snn_spike_collector.sv
// SNN output spike collector.
// Counts spikes per output class over a frame of NUM_TICKS ticks, scans the
// counters one class per cycle for the winner (lowest index wins ties), and
// pushes the winner into a small result FIFO drained by the system side.
// Optional feature macro SNN_SPIKE_COLLECTOR_COUNT_EN: when defined, each
// result also carries the winning spike count as {count, index}.
module snn_spike_collector
  import snn_collector_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int NUM_TICKS   = DEF_NUM_TICKS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RFIFO_DEPTH = DEF_RFIFO_DEPTH,
  localparam int CLS_W      = clsWidth(NUM_CLASSES),
`ifdef SNN_SPIKE_COLLECTOR_COUNT_EN
  localparam int RES_W      = CNT_W + CLS_W
`else
  localparam int RES_W      = CLS_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [7:0]       packet_in,
  input  logic             packet_in_valid,
  input  logic             result_ren,
  output logic [RES_W-1:0] result_rdata,
  output logic             result_empty,
  output logic             frame_busy,
  output logic             drop_error,
  output logic             overflow_error
);

  localparam int TICK_W = (NUM_TICKS > 1) ? $clog2(NUM_TICKS) : 1;

  state_e            state_q;
  logic [TICK_W-1:0] tickCnt_q;
  logic [CLS_W-1:0]  scanIdx_q;
  logic [CLS_W-1:0]  bestIdx_q;
  logic [CNT_W-1:0]  bestCnt_q;
  logic [CNT_W-1:0]  cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0]  cnt_d [NUM_CLASSES];
  logic [CNT_W-1:0]  scanCnt;
  logic              dropError_q;
  logic              overflowError_q;
  logic              fifoFull;
  logic              fifoPush;
  logic [RES_W-1:0]  resData;

  assign frame_busy     = (state_q != COUNT);
  assign drop_error     = dropError_q;
  assign overflow_error = overflowError_q;
  assign fifoPush       = (state_q == PUSH);

`ifdef SNN_SPIKE_COLLECTOR_COUNT_EN
  assign resData = {bestCnt_q, bestIdx_q};
`else
  assign resData = bestIdx_q;
`endif

  // Per-class counter update: saturating increment while counting, clear once scanned.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((state_q == COUNT) && packet_in_valid && (int'(packet_in) == i) &&
          (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if ((state_q == SCAN) && (int'(scanIdx_q) == i)) begin
        cnt_d[i] = '0;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Select the counter addressed by the scan index.
  always_comb begin
    scanCnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (int'(scanIdx_q) == i) begin
        scanCnt = cnt_q[i];
      end
    end
  end

  // Frame FSM: count ticks, scan for the winner, then push it; also tracks the sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= COUNT;
      tickCnt_q       <= '0;
      scanIdx_q       <= '0;
      bestIdx_q       <= '0;
      bestCnt_q       <= '0;
      dropError_q     <= 1'b0;
      overflowError_q <= 1'b0;
    end else begin
      case (state_q)
        COUNT: begin
          if (tick) begin
            if (int'(tickCnt_q) == NUM_TICKS - 1) begin
              tickCnt_q <= '0;
              scanIdx_q <= '0;
              state_q   <= SCAN;
            end else begin
              tickCnt_q <= tickCnt_q + TICK_W'(1);
            end
          end
        end
        SCAN: begin
          if ((scanIdx_q == '0) || (scanCnt > bestCnt_q)) begin
            bestCnt_q <= scanCnt;
            bestIdx_q <= scanIdx_q;
          end
          if (int'(scanIdx_q) == NUM_CLASSES - 1) begin
            state_q <= PUSH;
          end else begin
            scanIdx_q <= scanIdx_q + CLS_W'(1);
          end
          if (packet_in_valid || tick) begin
            dropError_q <= 1'b1;
          end
        end
        PUSH: begin
          if (fifoFull && !result_ren) begin
            overflowError_q <= 1'b1;
          end
          if (packet_in_valid || tick) begin
            dropError_q <= 1'b1;
          end
          state_q <= COUNT;
        end
        default: begin
          state_q <= COUNT;
        end
      endcase
    end
  end

  snn_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RFIFO_DEPTH)
  ) u_result_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifoPush),
    .wdata_i (resData),
    .pop_i   (result_ren),
    .rdata_o (result_rdata),
    .empty_o (result_empty),
    .full_o  (fifoFull)
  );

endmodule

// File: tb/tb_snn_spike_collector.sv
// Testbench for snn_spike_collector (NUM_TICKS=4, CNT_W=4 so saturation is reachable).
// A frame-level model keeps per-class spike totals and a queue of expected results.
module tb_snn_spike_collector;
  import snn_collector_pkg::*;

  localparam int NUM_CLASSES = 10;
  localparam int NUM_TICKS   = 4;
  localparam int CNT_W       = 4;
  localparam int RFIFO_DEPTH = 4;
  localparam int CLS_W       = clsWidth(NUM_CLASSES);
`ifdef SNN_SPIKE_COLLECTOR_COUNT_EN
  localparam int RES_W       = CNT_W + CLS_W;
`else
  localparam int RES_W       = CLS_W;
`endif
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic [7:0]       packet_in;
  logic             packet_in_valid;
  logic             result_ren;
  logic [RES_W-1:0] result_rdata;
  logic             result_empty;
  logic             frame_busy;
  logic             drop_error;
  logic             overflow_error;

  int               assertCount = 0;
  int               failCount = 0;
  int               modelCnt [NUM_CLASSES];
  int               modelTicks;
  logic [RES_W-1:0] expQ [$];
  logic [RES_W-1:0] pendingRes;
  bit               pendingValid;
  bit               expDrop;
  bit               expOverflow;

  snn_spike_collector #(
    .NUM_CLASSES (NUM_CLASSES),
    .NUM_TICKS   (NUM_TICKS),
    .CNT_W       (CNT_W),
    .RFIFO_DEPTH (RFIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .result_ren      (result_ren),
    .result_rdata    (result_rdata),
    .result_empty    (result_empty),
    .frame_busy      (frame_busy),
    .drop_error      (drop_error),
    .overflow_error  (overflow_error)
  );

  always #5 clk = ~clk;

  // Build a result word from a winning class and its spike total.
  function automatic logic [RES_W-1:0] mkRes(input int idx, input int cnt);
    logic [RES_W-1:0] r;
`ifdef SNN_SPIKE_COLLECTOR_COUNT_EN
    r = {CNT_W'(cnt), CLS_W'(idx)};
`else
    r = CLS_W'(idx);
`endif
    return r;
  endfunction

  task automatic modelResetAll();
    modelCnt     = '{default: 0};
    modelTicks   = 0;
    expQ.delete();
    pendingValid = 1'b0;
    expDrop      = 1'b0;
    expOverflow  = 1'b0;
  endtask

  // One counting cycle: drive inputs and fold them into the frame model.
  task automatic countCycle(input bit v, input int idx, input bit tk);
    int best;
    @(negedge clk);
    packet_in_valid = v;
    packet_in       = idx[7:0];
    tick            = tk;
    if (v && idx < NUM_CLASSES) begin
      modelCnt[idx] = (modelCnt[idx] < MAXC) ? modelCnt[idx] + 1 : MAXC;
    end
    if (tk) begin
      modelTicks++;
      if (modelTicks == NUM_TICKS) begin
        best = 0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
          if (modelCnt[i] > modelCnt[best]) best = i;
        end
        pendingRes   = mkRes(best, modelCnt[best]);
        pendingValid = 1'b1;
        modelCnt     = '{default: 0};
        modelTicks   = 0;
      end
    end
  endtask

  task automatic tickOnly(input int n);
    for (int i = 0; i < n; i++) countCycle(1'b0, 0, 1'b1);
  endtask

  // Idle through SCAN and PUSH, optionally injecting stray traffic or a pop during PUSH.
  task automatic finishFrame(input int dropFrom, input int dropTo, input int popAt);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      packet_in_valid = 1'b0;
      packet_in       = 8'd0;
      tick            = 1'b0;
      result_ren      = 1'b0;
      if (k >= dropFrom && k <= dropTo) begin
        packet_in_valid = 1'b1;
        tick            = 1'b1;
        expDrop         = 1'b1;
      end
      if (k == popAt) begin
        result_ren = 1'b1;
        if (expQ.size() > 0) void'(expQ.pop_front());
      end
    end
    if (pendingValid) begin
      if (expQ.size() < RFIFO_DEPTH) expQ.push_back(pendingRes);
      else expOverflow = 1'b1;
      pendingValid = 1'b0;
    end
  endtask

  task automatic popItem();
    result_ren = 1'b1;
    if (expQ.size() > 0) void'(expQ.pop_front());
    @(negedge clk);
    result_ren = 1'b0;
  endtask

  task automatic randomFrame();
    int n;
    for (int t = 0; t < NUM_TICKS; t++) begin
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        countCycle($urandom_range(0, 4) != 0, $urandom_range(0, 12), 1'b0);
      end
      countCycle($urandom_range(0, 1) == 1, $urandom_range(0, 12), 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; packet_in = 8'd0; packet_in_valid = 1'b0; result_ren = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++; if (result_empty !== 1'b1) begin failCount++; $display("[TB] FAIL reset_empty: got %b expected 1", result_empty); end
    assertCount++; if (result_rdata !== '0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", result_rdata); end
    assertCount++; if (frame_busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", frame_busy); end
    assertCount++; if (drop_error !== 1'b0) begin failCount++; $display("[TB] FAIL reset_drop: got %b expected 0", drop_error); end
    assertCount++; if (overflow_error !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_error); end
    reset = 1'b0;
    modelResetAll();
  endtask

  // Spikes 3,3,3,7,7 over four ticks; result must appear exactly 12 cycles after the last tick.
  task automatic test_frame_latency();
    countCycle(1'b1, 3, 1'b0);
    countCycle(1'b1, 3, 1'b1);
    countCycle(1'b1, 3, 1'b0);
    countCycle(1'b1, 7, 1'b1);
    countCycle(1'b0, 0, 1'b1);
    countCycle(1'b1, 7, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      packet_in_valid = 1'b0; tick = 1'b0; packet_in = 8'd0;
      if (k == 1) begin
        assertCount++; if (frame_busy !== 1'b1) begin failCount++; $display("[TB] FAIL lat_busy_scan: got %b expected 1", frame_busy); end
      end
      if (k == 11) begin
        assertCount++; if (result_empty !== 1'b1) begin failCount++; $display("[TB] FAIL lat_empty_early: got %b expected 1", result_empty); end
      end
      if (k == 12) begin
        assertCount++; if (result_empty !== 1'b0) begin failCount++; $display("[TB] FAIL lat_empty_on_time: got %b expected 0", result_empty); end
        assertCount++; if (result_rdata !== mkRes(3, 3)) begin failCount++; $display("[TB] FAIL lat_rdata: got %h expected %h", result_rdata, mkRes(3, 3)); end
        assertCount++; if (frame_busy !== 1'b0) begin failCount++; $display("[TB] FAIL lat_busy_done: got %b expected 0", frame_busy); end
      end
    end
    expQ.push_back(pendingRes);
    pendingValid = 1'b0;
    popItem();
    assertCount++; if (result_empty !== 1'b1) begin failCount++; $display("[TB] FAIL lat_pop_empty: got %b expected 1", result_empty); end
  endtask

  task automatic test_tie();
    countCycle(1'b1, 5, 1'b0); countCycle(1'b1, 5, 1'b0);
    countCycle(1'b1, 2, 1'b0); countCycle(1'b1, 2, 1'b0);
    tickOnly(NUM_TICKS);
    finishFrame(0, -1, -1);
    assertCount++; if (result_rdata !== mkRes(2, 2)) begin failCount++; $display("[TB] FAIL tie_rdata: got %h expected %h", result_rdata, mkRes(2, 2)); end
    popItem();
    tickOnly(NUM_TICKS);
    finishFrame(0, -1, -1);
    assertCount++; if (result_rdata !== mkRes(0, 0) || result_empty !== 1'b0) begin failCount++; $display("[TB] FAIL zero_frame: got %h empty %b expected %h", result_rdata, result_empty, mkRes(0, 0)); end
    popItem();
  endtask

  task automatic test_ignore_index();
    countCycle(1'b1, 200, 1'b0);
    countCycle(1'b1, 9, 1'b0);
    tickOnly(NUM_TICKS);
    finishFrame(0, -1, -1);
    assertCount++; if (result_rdata !== mkRes(9, 1)) begin failCount++; $display("[TB] FAIL ignore_rdata: got %h expected %h", result_rdata, mkRes(9, 1)); end
    assertCount++; if (drop_error !== 1'b0 || overflow_error !== 1'b0) begin failCount++; $display("[TB] FAIL ignore_errors: got drop %b ovf %b expected 0 0", drop_error, overflow_error); end
    popItem();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) countCycle(1'b1, 1, 1'b0);
    for (int i = 0; i < 15; i++) countCycle(1'b1, 6, 1'b0);
    tickOnly(NUM_TICKS);
    finishFrame(0, -1, -1);
    assertCount++; if (result_rdata !== mkRes(1, MAXC)) begin failCount++; $display("[TB] FAIL saturate_rdata: got %h expected %h", result_rdata, mkRes(1, MAXC)); end
    popItem();
  endtask

  // Stray spikes and ticks to class 0 during SCAN must not leak into the next frame.
  task automatic test_drop();
    countCycle(1'b1, 1, 1'b0); countCycle(1'b1, 1, 1'b0);
    tickOnly(NUM_TICKS);
    finishFrame(2, 4, -1);
    assertCount++; if (drop_error !== 1'b1) begin failCount++; $display("[TB] FAIL drop_flag: got %b expected 1", drop_error); end
    assertCount++; if (result_rdata !== mkRes(1, 2)) begin failCount++; $display("[TB] FAIL drop_rdata: got %h expected %h", result_rdata, mkRes(1, 2)); end
    popItem();
    tickOnly(NUM_TICKS - 1);
    countCycle(1'b1, 4, 1'b1);
    finishFrame(0, -1, -1);
    assertCount++; if (result_rdata !== mkRes(4, 1)) begin failCount++; $display("[TB] FAIL final_tick_spike: got %h expected %h", result_rdata, mkRes(4, 1)); end
    assertCount++; if (drop_error !== expDrop) begin failCount++; $display("[TB] FAIL drop_sticky: got %b expected %b", drop_error, expDrop); end
    popItem();
  endtask

  task automatic test_overflow();
    logic [RES_W-1:0] e;
    for (int f = 0; f < RFIFO_DEPTH; f++) begin
      randomFrame();
      finishFrame(0, -1, -1);
    end
    assertCount++; if (overflow_error !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_when_full: got %b expected 0", overflow_error); end
    randomFrame();
    finishFrame(0, -1, 11);
    assertCount++; if (overflow_error !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_push_pop_full: got %b expected 0", overflow_error); end
    randomFrame();
    finishFrame(0, -1, -1);
    assertCount++; if (overflow_error !== 1'b1 || expOverflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow_error); end
    for (int p = 0; p < RFIFO_DEPTH; p++) begin
      e = (expQ.size() > 0) ? expQ[0] : '0;
      assertCount++; if (result_empty !== 1'b0 || result_rdata !== e) begin failCount++; $display("[TB] FAIL ovf_pop%0d: got %h empty %b expected %h", p, result_rdata, result_empty, e); end
      popItem();
    end
    assertCount++; if (result_empty !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_drained: got %b expected 1", result_empty); end
    popItem();
    assertCount++; if (result_empty !== 1'b1 || result_rdata !== '0) begin failCount++; $display("[TB] FAIL pop_when_empty: got empty %b rdata %h expected 1 0", result_empty, result_rdata); end
  endtask

  task automatic test_reset_during_scan();
    for (int i = 0; i < 3; i++) countCycle(1'b1, 5, 1'b0);
    tickOnly(NUM_TICKS);
    @(negedge clk); packet_in_valid = 1'b0; tick = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    assertCount++; if (result_empty !== 1'b1 || result_rdata !== '0 || frame_busy !== 1'b0) begin failCount++; $display("[TB] FAIL scan_reset_outputs: got empty %b rdata %h busy %b expected 1 0 0", result_empty, result_rdata, frame_busy); end
    assertCount++; if (drop_error !== 1'b0 || overflow_error !== 1'b0) begin failCount++; $display("[TB] FAIL scan_reset_errors: got drop %b ovf %b expected 0 0", drop_error, overflow_error); end
    reset = 1'b0;
    modelResetAll();
    countCycle(1'b1, 8, 1'b0);
    tickOnly(NUM_TICKS);
    finishFrame(0, -1, -1);
    assertCount++; if (result_rdata !== mkRes(8, 1)) begin failCount++; $display("[TB] FAIL scan_reset_next: got %h expected %h", result_rdata, mkRes(8, 1)); end
    popItem();
  endtask

  task automatic test_random_frames();
    logic [RES_W-1:0] e;
    for (int f = 0; f < 6; f++) begin
      randomFrame();
      finishFrame(0, -1, -1);
      e = (expQ.size() > 0) ? expQ[0] : '0;
      assertCount++; if (result_empty !== 1'b0 || result_rdata !== e) begin failCount++; $display("[TB] FAIL random_frame%0d: got %h empty %b expected %h", f, result_rdata, result_empty, e); end
      popItem();
    end
    assertCount++; if (overflow_error !== expOverflow || drop_error !== expDrop) begin failCount++; $display("[TB] FAIL random_errors: got drop %b ovf %b expected %b %b", drop_error, overflow_error, expDrop, expOverflow); end
  endtask

  initial begin
    test_reset();
    test_frame_latency();
    test_tie();
    test_ignore_index();
    test_saturate();
    test_drop();
    test_overflow();
    test_reset_during_scan();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
